// File: rtl/von_pkg.sv
// Shared opcode and FSM state definitions for the accumulator CPU controller and its ALU bench.
package von_pkg;

  localparam int unsigned OPC_W = 3;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SHL   = 3'b001,
    OP_XNOR  = 3'b010,
    OP_SHR   = 3'b011,
    OP_LOAD  = 3'b100,
    OP_STORE = 3'b101,
    OP_NEG   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_e;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_OPFETCH = 4'd3,
    ST_OPLATCH = 4'd4,
    ST_EXEC    = 4'd5,
    ST_WB      = 4'd6,
    ST_STORE   = 4'd7,
    ST_HALT    = 4'd8
  } state_e;

endpackage

// File: rtl/cpu_control_von.sv
// Multi-cycle control FSM for a von Neumann accumulator CPU with a unified memory
// and an external ALU; every output is a flop computed from the next state.
module cpu_control_von
  import von_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] alu_result,
  output logic [OPC_W-1:0]  alu_mode,
  output logic              alu_activate,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] dr,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ac_q, ac_d;
  logic [DATA_W-1:0]   dr_q, dr_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [OPC_W-1:0]    alu_mode_q, alu_mode_d;
  logic                alu_act_q, alu_act_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  opcode_e             rd_op;

  assign rd_op = opcode_e'(mem_rdata[DATA_W-1 -: OPC_W]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      ac_q        <= '0;
      dr_q        <= '0;
      ir_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      alu_mode_q  <= '0;
      alu_act_q   <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ac_q        <= ac_d;
      dr_q        <= dr_d;
      ir_q        <= ir_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      alu_mode_q  <= alu_mode_d;
      alu_act_q   <= alu_act_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  // Next state and datapath register updates; the instruction byte is only valid during DECODE.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ac_d    = ac_q;
    dr_d    = dr_q;
    ir_d    = ir_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d = mem_rdata;
        pc_d = pc_q + ADDR_W'(1);
        unique case (rd_op)
          OP_STORE: state_d = ST_STORE;
          OP_NEG:   state_d = ST_EXEC;
          OP_HALT:  state_d = ST_HALT;
          default:  state_d = ST_OPFETCH;
        endcase
      end
      ST_OPFETCH: state_d = ST_OPLATCH;
      ST_OPLATCH: begin
        dr_d    = mem_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC:    state_d = ST_WB;
      ST_WB: begin
        ac_d    = alu_result;
        state_d = ST_FETCH;
      end
      ST_STORE:   state_d = ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are derived from the state being entered so they line up with it.
  always_comb begin
    mem_addr_d  = '0;
    mem_wdata_d = ac_d;
    mem_we_d    = (state_d == ST_STORE);
    alu_act_d   = (state_d == ST_EXEC);
    alu_mode_d  = ir_d[DATA_W-1 -: OPC_W];
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_HALT);
    halted_d    = (state_d == ST_HALT);

    unique case (state_d)
      ST_FETCH:                        mem_addr_d = pc_d;
      ST_DECODE:                       mem_addr_d = mem_addr_q;
      ST_OPFETCH, ST_OPLATCH, ST_STORE: mem_addr_d = ir_d[ADDR_W-1:0];
      default:                         mem_addr_d = '0;
    endcase
  end

  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_we       = mem_we_q;
  assign alu_mode     = alu_mode_q;
  assign alu_activate = alu_act_q;
  assign ac           = ac_q;
  assign dr           = dr_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_cpu_control_von.sv
// Bench for cpu_control_von: 32-byte memory, a registered ALU stand-in, and an
// instruction-level reference interpreter checked at every instruction boundary.
module tb_cpu_control_von;
  import von_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] alu_result = 8'h00;
  logic [2:0] alu_mode;
  logic       alu_activate;
  logic [7:0] ac, dr;
  logic [4:0] pc;
  logic       busy, halted;

  logic [7:0] mem [32];
  logic [7:0] img [32];
  logic       load_req = 1'b0;
  int         we_cnt = 0;
  int         act_cnt = 0;
  int         act_dbl = 0;
  logic       act_prev = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_control_von #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .alu_result(alu_result), .alu_mode(alu_mode), .alu_activate(alu_activate),
    .ac(ac), .dr(dr), .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
    case (op)
      3'd0:    return 8'((int'(a) + int'(d)) % 256);
      3'd1:    return 8'((int'(a) * 2) % 256);
      3'd2:    return ~(a ^ d);
      3'd3:    return 8'(int'(a) / 2);
      3'd4:    return d;
      3'd6:    return 8'((256 - int'(a)) % 256);
      default: return 8'h00;
    endcase
  endfunction

  // Synchronous memory (read data one cycle after the address) and the ALU stand-in.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 32; i++) mem[i] <= img[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
    if (alu_activate) alu_result <= alu_fn(alu_mode, ac, dr);
    if (!rst) begin
      if (mem_we) we_cnt <= we_cnt + 1;
      if (alu_activate) act_cnt <= act_cnt + 1;
      if (alu_activate && act_prev) act_dbl <= act_dbl + 1;
    end
    act_prev <= alu_activate;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic load_mem();
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
  endtask

  // Executes the loaded image from a fresh reset and compares against the interpreter.
  task automatic run_prog(input string name, input int max_steps, input bit noisy);
    logic [7:0] m [32];
    int pc_m, ac_m, dr_m, ir, op, a, lat, we0, act0, dbl0, we_exp, act_exp, bad;
    for (int i = 0; i < 32; i++) m[i] = img[i];
    pc_m = 0; ac_m = 0; dr_m = 0; we_exp = 0; act_exp = 0;
    we0 = we_cnt; act0 = act_cnt; dbl0 = act_dbl;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({name, "_start_busy"}, busy, 1);
    check({name, "_start_pc"}, pc, 0);
    for (int s = 0; s < max_steps; s++) begin
      ir = m[pc_m];
      op = ir / 32;
      a  = ir % 32;
      pc_m = (pc_m + 1) % 32;
      if (noisy) start = 1'($urandom_range(0, 1));
      if (op == 7) begin
        repeat (2) @(posedge clk);
        #1;
        check({name, "_halted"}, halted, 1);
        check({name, "_halt_busy"}, busy, 0);
        check({name, "_halt_pc"}, pc, pc_m);
        repeat (4) begin
          @(posedge clk); #1 start = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        check({name, "_halt_sticky"}, {halted, busy, mem_addr}, {1'b1, 1'b0, 5'd0});
        check({name, "_halt_pc2"}, pc, pc_m);
        break;
      end
      if (op == 5) begin
        m[a] = 8'(ac_m);
        lat = 3;
        we_exp++;
      end else if (op == 6) begin
        ac_m = (256 - ac_m) % 256;
        lat = 4;
        act_exp++;
      end else begin
        dr_m = m[a];
        ac_m = alu_fn(3'(op), 8'(ac_m), 8'(dr_m));
        lat = 6;
        act_exp++;
      end
      repeat (lat) @(posedge clk);
      #1;
      check({name, "_pc"}, pc, pc_m);
      check({name, "_ac"}, ac, ac_m);
      check({name, "_dr"}, dr, dr_m);
      check({name, "_fetch_addr"}, mem_addr, pc_m);
      check({name, "_busy"}, busy, 1);
    end
    start = 1'b0;
    check({name, "_we_pulses"}, we_cnt - we0, we_exp);
    check({name, "_alu_pulses"}, act_cnt - act0, act_exp);
    check({name, "_alu_double"}, act_dbl - dbl0, 0);
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== m[i]) bad++;
    check({name, "_mem_words_bad"}, bad, 0);
  endtask

  initial begin
    int n;
    clear_img();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_pc", pc, 0);
    check("rst_ac", ac, 0);
    check("rst_dr", dr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_we", mem_we, 0);
    check("rst_alu", {alu_mode, alu_activate}, 0);
    check("rst_flags", {busy, halted}, 0);

    // LOAD 5; HALT
    clear_img();
    img[0] = 8'h85; img[1] = 8'hE0; img[5] = 8'h12;
    load_mem(); do_reset();
    run_prog("load_halt", 4, 1'b0);
    check("load_halt_ac", ac, 8'h12);
    check("load_halt_pc", pc, 2);

    // LOAD 5; ADD 6; STORE 7; HALT with wrap in the add
    clear_img();
    img[0] = 8'h85; img[1] = 8'h06; img[2] = 8'hA7; img[3] = 8'hE0;
    img[5] = 8'hF0; img[6] = 8'h20;
    load_mem(); do_reset();
    run_prog("add_store", 6, 1'b1);
    check("add_store_ac", ac, 8'h10);
    check("add_store_mem7", mem[7], 8'h10);

    // LOAD 5; NEG; HALT
    clear_img();
    img[0] = 8'h85; img[1] = 8'hC0; img[2] = 8'hE0; img[5] = 8'h05;
    load_mem(); do_reset();
    run_prog("neg", 4, 1'b1);
    check("neg_ac", ac, 8'hFB);

    // Memory full of LOAD 16: PC wraps and instruction 0 is fetched again
    for (int i = 0; i < 32; i++) img[i] = 8'h90;
    load_mem(); do_reset();
    run_prog("wrap", 33, 1'b1);
    check("wrap_pc", pc, 1);

    // Reset lands on the edge that would enter STORE: no write may happen
    clear_img();
    img[0] = 8'h90; img[1] = 8'hB1; img[2] = 8'hE0; img[16] = 8'h5A; img[17] = 8'h33;
    load_mem(); do_reset();
    n = we_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_store_outs", {pc, ac, dr, mem_addr, mem_wdata, alu_mode}, 0);
    check("rst_store_ctl", {mem_we, alu_activate, busy, halted}, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_store_mem17", mem[17], 8'h33);
    check("rst_store_we_cnt", we_cnt - n, 0);
    check("rst_store_idle", {busy, halted, mem_we}, 0);

    // Random programs: data in 16..31, HALT after the last instruction
    for (int p = 0; p < 20; p++) begin
      n = $urandom_range(3, 12);
      for (int i = 0; i < 32; i++) img[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < n; i++)
        img[i] = 8'({3'($urandom_range(0, 6)), 5'($urandom_range(16, 31))});
      img[n] = 8'hE0;
      load_mem(); do_reset();
      run_prog("rand", n + 1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
